// File: rtl/mandel_iter.sv
// Mandelbrot pixel sequencer: iterates z <= z^2 + c on one shared external multiplier.
// Three products per iteration; handshakes with the mul on start/done; no fixed mul latency.
module mandel_iter #(
  parameter int ITER_W = 8,
  parameter int FRAC   = 4,
  parameter int ESC    = 4 << FRAC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [24:0]       cr,
  input  logic signed [24:0]       ci,
  input  logic        [ITER_W-1:0] max_iter,
  output logic                     busy,
  output logic                     done,
  output logic        [ITER_W-1:0] iter,
  output logic                     escaped,
  output logic                     ovf,
  output logic                     mul_start,
  output logic signed [24:0]       mul_a,
  output logic signed [24:0]       mul_b,
  input  logic                     mul_done,
  input  logic                     mul_ovf,
  input  logic signed [24:0]       mul_val
);

  typedef enum logic [2:0] {
    S_IDLE, S_SQR, S_SQI, S_XRI, S_CHECK, S_UPDATE, S_FIN
  } state_t;

  localparam logic signed [25:0] ESC_V = 26'(ESC);

  state_t state, state_n;
  logic signed [24:0] cr_q, ci_q, zr, zi, zr2, zi2, zrzi;
  logic [ITER_W-1:0] max_q;
  logic signed [25:0] mag;
  logic signed [26:0] zr_new, zi_new;
  logic mul_ack, upd_ovf, esc_hit, set_ovf, set_esc, enter_fin;

  // A done arriving in the same cycle as our own start pulse cannot belong to it.
  assign mul_ack = mul_done & ~mul_start;
  assign mag     = {zr2[24], zr2} + {zi2[24], zi2};
  assign esc_hit = mag > ESC_V;
  assign zr_new  = {{2{zr2[24]}}, zr2} - {{2{zi2[24]}}, zi2} + {{2{cr_q[24]}}, cr_q};
  assign zi_new  = {zrzi[24], zrzi, 1'b0} + {{2{ci_q[24]}}, ci_q};
  assign upd_ovf = !((zr_new[26:24] == 3'b000) || (zr_new[26:24] == 3'b111)) ||
                   !((zi_new[26:24] == 3'b000) || (zi_new[26:24] == 3'b111));

  always_comb begin
    state_n = state;
    set_ovf = 1'b0;
    set_esc = 1'b0;
    case (state)
      S_IDLE: if (start) state_n = S_SQR;
      S_SQR, S_SQI, S_XRI: begin
        if (mul_ack) begin
          if (mul_ovf) begin
            set_ovf = 1'b1;
            set_esc = 1'b1;
            state_n = S_FIN;
          end else begin
            case (state)
              S_SQR:   state_n = S_SQI;
              S_SQI:   state_n = S_XRI;
              default: state_n = S_CHECK;
            endcase
          end
        end
      end
      S_CHECK: begin
        if (esc_hit) begin
          set_esc = 1'b1;
          state_n = S_FIN;
        end else if (iter == max_q) begin
          state_n = S_FIN;
        end else begin
          state_n = S_UPDATE;
        end
      end
      S_UPDATE: begin
        if (upd_ovf) begin
          set_ovf = 1'b1;
          set_esc = 1'b1;
          state_n = S_FIN;
        end else begin
          state_n = S_SQR;
        end
      end
      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign enter_fin = (state_n == S_FIN) && (state != S_FIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      iter      <= '0;
      escaped   <= 1'b0;
      ovf       <= 1'b0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      cr_q      <= '0;
      ci_q      <= '0;
      max_q     <= '0;
      zr        <= '0;
      zi        <= '0;
      zr2       <= '0;
      zi2       <= '0;
      zrzi      <= '0;
    end else begin
      state     <= state_n;
      mul_start <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cr_q      <= cr;
            ci_q      <= ci;
            max_q     <= max_iter;
            zr        <= '0;
            zi        <= '0;
            iter      <= '0;
            busy      <= 1'b1;
            escaped   <= 1'b0;
            ovf       <= 1'b0;
            mul_start <= 1'b1;
            mul_a     <= '0;
            mul_b     <= '0;
          end
        end
        S_SQR: begin
          if (mul_ack) begin
            zr2 <= mul_val;
            if (!mul_ovf) begin
              mul_start <= 1'b1;
              mul_a     <= zi;
              mul_b     <= zi;
            end
          end
        end
        S_SQI: begin
          if (mul_ack) begin
            zi2 <= mul_val;
            if (!mul_ovf) begin
              mul_start <= 1'b1;
              mul_a     <= zr;
              mul_b     <= zi;
            end
          end
        end
        S_XRI: if (mul_ack) zrzi <= mul_val;
        S_UPDATE: begin
          if (!upd_ovf) begin
            zr        <= zr_new[24:0];
            zi        <= zi_new[24:0];
            iter      <= iter + ITER_W'(1);
            mul_start <= 1'b1;
            mul_a     <= zr_new[24:0];
            mul_b     <= zr_new[24:0];
          end
        end
        default: ;
      endcase
      // Results become visible together with the done pulse in FIN.
      if (enter_fin) begin
        done <= 1'b1;
        busy <= 1'b0;
        if (set_ovf) ovf <= 1'b1;
        if (set_esc) escaped <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mandel_iter.sv
// Bench for mandel_iter: behavioural multiplier on the mul port plus a plain-arithmetic
// pixel model; directed pixels, randomized pixels, reset abort and ignored-input cases.
module tb_mandel_iter;
  localparam int FRAC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start;
  logic signed [24:0] cr, ci;
  logic [7:0] max_iter;
  logic busy, done, escaped, ovf, mul_start;
  logic [7:0] iter;
  logic signed [24:0] mul_a, mul_b;
  logic signed [24:0] mul_val = '0;
  logic mul_ovf = 1'b0;
  logic model_done = 1'b0;
  logic stray_done;
  logic mul_done;
  assign mul_done = model_done | stray_done;

  int checks = 0;
  int failures = 0;
  int mul_count = 0;
  int proto_err = 0;
  int pend_cnt = 0;
  logic signed [24:0] pa, pb;
  longint prod;

  mandel_iter #(.ITER_W(8), .FRAC(FRAC), .ESC(64)) dut (
    .clk(clk), .rst(rst), .start(start), .cr(cr), .ci(ci), .max_iter(max_iter),
    .busy(busy), .done(done), .iter(iter), .escaped(escaped), .ovf(ovf),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_ovf(mul_ovf), .mul_val(mul_val)
  );

  // Multiplier: product >>> FRAC, overflow outside 25-bit signed, done 4 cycles after start.
  always @(negedge clk) begin
    model_done = 1'b0;
    mul_ovf    = 1'b0;
    if (rst) begin
      pend_cnt = 0;
    end else if (mul_start) begin
      if (pend_cnt != 0) proto_err++;
      mul_count++;
      pa = mul_a;
      pb = mul_b;
      pend_cnt = 4;
    end else if (pend_cnt > 0) begin
      if (mul_a !== pa || mul_b !== pb) proto_err++;
      pend_cnt--;
      if (pend_cnt == 0) begin
        prod = (longint'(pa) * longint'(pb)) >>> FRAC;
        model_done = 1'b1;
        mul_ovf = (prod > 64'sd16777215) || (prod < -64'sd16777216);
        mul_val = prod[24:0];
      end
    end
  end

  function automatic bit out25(input longint v);
    return (v > 64'sd16777215) || (v < -64'sd16777216);
  endfunction

  function automatic void ref_pixel(input longint c_r, input longint c_i, input int maxi,
                                    output int it, output bit esc, output bit ov, output int muls);
    longint zr, zi, p, nr, ni;
    longint prods[3];
    zr = 0; zi = 0; it = 0; esc = 0; ov = 0; muls = 0;
    for (int n = 0; n < 1000; n++) begin
      for (int k = 0; k < 3; k++) begin
        muls++;
        p = (k == 0) ? zr * zr : (k == 1) ? zi * zi : zr * zi;
        p = p >>> FRAC;
        if (out25(p)) begin ov = 1; esc = 1; return; end
        prods[k] = p;
      end
      if (prods[0] + prods[1] > 64) begin esc = 1; return; end
      if (it == maxi) return;
      nr = prods[0] - prods[1] + c_r;
      ni = 2 * prods[2] + c_i;
      if (out25(nr) || out25(ni)) begin ov = 1; esc = 1; return; end
      zr = nr; zi = ni; it++;
    end
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_pixel(input logic signed [24:0] c_r, input logic signed [24:0] c_i,
                           input logic [7:0] m_it, input bit poke,
                           output int got_it, output bit got_esc, output bit got_ovf,
                           output int got_muls);
    int e_it, e_muls, base, n;
    bit e_esc, e_ov, seen;
    ref_pixel(longint'(c_r), longint'(c_i), int'(m_it), e_it, e_esc, e_ov, e_muls);
    base = mul_count;
    cr = c_r; ci = c_i; max_iter = m_it; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    n = 0; seen = 0;
    while (!seen && n < 20000) begin
      if (poke && n == 5) begin
        start = 1'b1; cr = ~c_r; ci = ~c_i; max_iter = 8'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (done) seen = 1;
    end
    start = 1'b0;
    check("done_seen", seen, 1);
    got_it = int'(iter); got_esc = escaped; got_ovf = ovf; got_muls = mul_count - base;
    check("iter", iter, 64'(e_it));
    check("escaped", escaped, 64'(e_esc));
    check("ovf", ovf, 64'(e_ov));
    check("busy_at_done", busy, 0);
    check("mul_pulses", 64'(mul_count - base), 64'(e_muls));
    check("mul_protocol", 64'(proto_err), 0);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
  endtask

  int r_it, r_muls, pulses, base, n, v1, v2;
  bit r_esc, r_ovf;
  logic signed [24:0] rc_r, rc_i;

  initial begin
    rst = 1'b1; start = 1'b0; cr = '0; ci = '0; max_iter = '0; stray_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_iter", iter, 0);
    check("rst_escaped", escaped, 0);
    check("rst_ovf", ovf, 0);
    check("rst_mul_start", mul_start, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_pixel(25'sd0, 25'sd0, 8'd10, 0, r_it, r_esc, r_ovf, r_muls);
    check("zero_iter", 64'(r_it), 10);
    check("zero_esc", r_esc, 0);
    check("zero_muls", 64'(r_muls), 33);

    run_pixel(25'sd32, 25'sd0, 8'd50, 0, r_it, r_esc, r_ovf, r_muls);
    check("two_iter", 64'(r_it), 2);
    check("two_esc", r_esc, 1);
    check("two_ovf", r_ovf, 0);

    // start pulsed mid-pixel with different c and limit must be ignored
    run_pixel(25'sd0, 25'sd16, 8'd20, 1, r_it, r_esc, r_ovf, r_muls);
    check("cyc_iter", 64'(r_it), 20);
    check("cyc_esc", r_esc, 0);

    run_pixel(25'sd8388608, 25'sd0, 8'd10, 0, r_it, r_esc, r_ovf, r_muls);
    check("big_iter", 64'(r_it), 1);
    check("big_esc", r_esc, 1);
    check("big_ovf", r_ovf, 1);

    base = mul_count;
    stray_done = 1'b1;
    @(posedge clk); #1;
    stray_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("stray_busy", busy, 0);
    check("stray_done", done, 0);
    check("stray_iter", iter, 1);
    check("stray_ovf", ovf, 1);
    check("stray_esc", escaped, 1);
    check("stray_no_mul", 64'(mul_count - base), 0);

    run_pixel(25'sd5, 25'sd3, 8'd0, 0, r_it, r_esc, r_ovf, r_muls);
    check("max0_iter", 64'(r_it), 0);
    check("max0_esc", r_esc, 0);
    check("max0_muls", 64'(r_muls), 3);

    // abort while waiting on the second product of the first iteration
    base = mul_count;
    cr = 25'sd0; ci = 25'sd16; max_iter = 8'd200; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (mul_count - base < 2 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_sqi", 64'(mul_count - base), 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_mul_start", mul_start, 0);
    pulses = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("abort_no_done", 64'(pulses), 0);
    run_pixel(25'sd32, 25'sd0, 8'd50, 0, r_it, r_esc, r_ovf, r_muls);
    check("after_abort_iter", 64'(r_it), 2);

    for (int t = 0; t < 14; t++) begin
      if (t % 4 == 3) begin
        v1 = int'($urandom_range(0, 16777215));
        v2 = int'($urandom_range(0, 16777215));
        if ($urandom_range(0, 1) == 1) v1 = -v1;
        if ($urandom_range(0, 1) == 1) v2 = -v2;
      end else begin
        v1 = int'($urandom_range(0, 160)) - 80;
        v2 = int'($urandom_range(0, 160)) - 80;
      end
      rc_r = 25'(v1);
      rc_i = 25'(v2);
      run_pixel(rc_r, rc_i, 8'($urandom_range(0, 40)), t % 5 == 2, r_it, r_esc, r_ovf, r_muls);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
